multicycle_mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 24 ++
 rtl/mem_resp_array.sv | 62 ++++++
 rtl/multicycle_mem_responder.sv | 135 +++++++++++++
 tb/tb_multicycle_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pkg
// Purpose  : Shared types and constants for the multicycle memory responder.
// Revision : 1.0  initial release
// ============================================================================
package mem_resp_pkg;

  // Default interface widths of the 16-bit core's unified memory port
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Wait-state counter width; WAIT_CYCLES must fit (0..15)
  localparam int CNT_W = 4;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/mem_resp_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_array
// Purpose  : Single-port DEPTH x DATA_W storage with synchronous byte-enabled
//            write and a registered read port that can also be cleared.
// Revision : 1.0  initial release
// ============================================================================
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [1:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately left unreset; only the read register is reset.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write: each lane updates only when its enable bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en && be[i]) begin
        mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register next value: clear wins (out-of-range read), else load on read
  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr) begin
      rdata_d = '0;
    end else if (rd_en) begin
      rdata_d = mem_q[idx];
    end
  end

  // Read register holds its value across writes and idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : mem_resp_array
`default_nettype wire

// File: rtl/multicycle_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_mem_responder
// Purpose  : Memory-side responder for the multicycle core's unified port.
//            Accepts one request at a time, inserts WAIT_CYCLES wait states,
//            commits the access and pulses done for one cycle.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0]    C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   C_WAIT  = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              we_q,    we_d;
  logic [1:0]        be_q,    be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  logic commit;
  logic in_range;

  // The access commits on the edge that leaves WAIT with an exhausted counter
  assign commit   = (state_q == ST_WAIT) && (cnt_q == '0);
  assign in_range = ({1'b0, addr_q} < C_DEPTH);

  // Next-state, request latching and completion flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          be_d    = be;
          wdata_d = wdata;
          cnt_d   = C_WAIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = ~in_range;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, request and completion registers; reset aborts any access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Storage: out-of-range accesses never touch it; out-of-range reads clear rdata
  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (commit &  we_q &  in_range),
    .rd_en  (commit & ~we_q &  in_range),
    .rd_clr (commit & ~we_q & ~in_range),
    .be     (be_q),
    .idx    (addr_q[IDX_W-1:0]),
    .wdata  (wdata_q),
    .rdata  (rdata)
  );

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule : multicycle_mem_responder
`default_nettype wire

// File: tb/tb_multicycle_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multicycle_mem_responder
// Purpose  : Scoreboard bench for two responder configurations
//            (WAIT_CYCLES=2/DEPTH=128 and WAIT_CYCLES=0/DEPTH=256).
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_mem_responder;

  localparam int W0 = 2;
  localparam int D0 = 128;
  localparam int W1 = 0;
  localparam int D1 = 256;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  be    = 2'b00;
  logic [7:0]  addr  = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic        sel   = 1'b0;

  logic        req0, req1;
  logic        ready0, done0, err0, ready1, done1, err1;
  logic [15:0] rdata0, rdata1;
  logic        m_ready, m_done, m_err;
  logic [15:0] m_rdata;

  assign req0 = req & ~sel;
  assign req1 = req &  sel;

  multicycle_mem_responder #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(D0), .WAIT_CYCLES(W0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready0), .done(done0), .rdata(rdata0), .err(err0)
  );

  multicycle_mem_responder #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(D1), .WAIT_CYCLES(W1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready1), .done(done1), .rdata(rdata1), .err(err1)
  );

  assign m_ready = sel ? ready1 : ready0;
  assign m_done  = sel ? done1  : done0;
  assign m_err   = sel ? err1   : err0;
  assign m_rdata = sel ? rdata1 : rdata0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int          exp_cyc;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mask;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [256];
  logic [15:0] known   [256];
  logic [15:0] last_rd   = 16'h0000;
  logic [15:0] last_mask = 16'hFFFF;
  int          last_acc  = -100;
  int          checks = 0;
  int          errors = 0;

  function automatic int cur_wait();
    return sel ? W1 : W0;
  endfunction

  function automatic int cur_depth();
    return sel ? D1 : D0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) known[i] = 16'h0000;
    last_rd   = 16'h0000;
    last_mask = 16'hFFFF;
    last_acc  = -100;
  endtask

  // Monitor: ready from the access window model, done/err/rdata from the queue
  always @(negedge clk) begin
    exp_t e;
    int   w;
    w = cur_wait();
    chk("ready", {31'd0, m_ready},
        {31'd0, !(last_acc >= 0 && cyc >= last_acc && cyc <= last_acc + w + 1)});
    if (m_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending access (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_latency", cyc, e.exp_cyc);
        chk("err", {31'd0, m_err}, {31'd0, e.err});
        checks++;
        if (((m_rdata ^ e.rdata) & e.mask) !== 16'h0000) begin
          errors++;
          $display("FAIL rdata: got %h expected %h mask %h (cycle %0d)",
                   m_rdata, e.rdata, e.mask, cyc);
        end
      end
    end else begin
      chk("err_without_done", {31'd0, m_err}, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!m_ready) begin
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got ready=0 for %0d cycles expected ready (cycle %0d)", n, cyc);
        ok  = 1'b0;
        req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // Present a request, wait for its acceptance edge, and record the expectation.
  task automatic issue(input bit w, input logic [1:0] b, input logic [7:0] a,
                       input logic [15:0] d, input bit hold);
    bit   ok;
    bit   inr;
    exp_t e;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    wait_ready(ok);
    if (!ok) return;
    @(posedge clk); #1;
    last_acc  = cyc;
    inr       = (int'(a) < cur_depth());
    e.exp_cyc = cyc + cur_wait() + 1;
    e.err     = ~inr;
    if (w) begin
      if (inr) begin
        for (int l = 0; l < 2; l++) begin
          if (b[l]) begin
            ref_mem[a][l*8 +: 8] = d[l*8 +: 8];
            known[a][l*8 +: 8]   = 8'hFF;
          end
        end
      end
    end else if (inr) begin
      last_rd   = ref_mem[a];
      last_mask = known[a];
    end else begin
      last_rd   = 16'h0000;
      last_mask = 16'hFFFF;
    end
    e.rdata = last_rd;
    e.mask  = last_mask;
    sb.push_back(e);
    if (!hold) begin
      req   = 1'b0;
      we    = 1'($urandom);
      be    = 2'($urandom);
      addr  = 8'($urandom);
      wdata = 16'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, m_ready}, 32'd1);
    chk({tag, "_done"},  {31'd0, m_done},  32'd0);
    chk({tag, "_err"},   {31'd0, m_err},   32'd0);
    chk({tag, "_rdata"}, {16'd0, m_rdata}, 32'd0);
  endtask

  // Accept a write, then pulse reset one cycle into WAIT so it never commits.
  task automatic issue_abort(input logic [7:0] a, input logic [15:0] d);
    bit ok;
    req = 1'b1; we = 1'b1; be = 2'b11; addr = a; wdata = d;
    wait_ready(ok);
    if (!ok) return;
    @(posedge clk); #1;
    last_acc = cyc;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_acc = -100;
    #1;
    chk_reset_outputs("abort_rst_async");
    @(posedge clk); #1;
    chk_reset_outputs("abort_rst_held");
    rst       = 1'b0;
    last_rd   = 16'h0000;
    last_mask = 16'hFFFF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic random_ops(input int count);
    bit          h, w;
    logic [7:0]  a;
    for (int i = 0; i < count; i++) begin
      h = ($urandom_range(0, 3) == 0) && (i != count - 1);
      w = 1'($urandom);
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      issue(w, 2'($urandom), a, 16'($urandom), h);
      if (!h) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("reset0");
    sel = 1'b1; #1;
    chk_reset_outputs("reset1");
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Configuration 0: WAIT_CYCLES=2, DEPTH=128
    issue(1'b1, 2'b11, 8'h10, 16'hBEEF, 1'b0);
    issue(1'b0, 2'b00, 8'h10, 16'h0000, 1'b0);
    issue(1'b1, 2'b11, 8'h20, 16'h1234, 1'b0);
    issue(1'b1, 2'b10, 8'h20, 16'hAB00, 1'b0);
    issue(1'b0, 2'b11, 8'h20, 16'h0000, 1'b0);
    issue(1'b0, 2'b00, 8'h10, 16'h0000, 1'b1);   // req stays high
    issue(1'b0, 2'b00, 8'h20, 16'h0000, 1'b0);
    issue(1'b1, 2'b11, 8'h40, 16'h7777, 1'b0);
    issue(1'b0, 2'b11, 8'hC0, 16'h0000, 1'b0);
    issue(1'b1, 2'b11, 8'hC0, 16'h1111, 1'b0);
    issue(1'b0, 2'b00, 8'h40, 16'h0000, 1'b0);
    issue(1'b1, 2'b00, 8'h40, 16'h2222, 1'b0);   // no lanes enabled
    issue(1'b0, 2'b00, 8'h40, 16'h0000, 1'b0);
    issue(1'b1, 2'b11, 8'h30, 16'h5555, 1'b0);
    issue(1'b0, 2'b00, 8'h30, 16'h0000, 1'b0);
    drain();
    issue_abort(8'h30, 16'hFFFF);
    issue(1'b0, 2'b00, 8'h30, 16'h0000, 1'b0);
    random_ops(150);
    drain();

    // Configuration 1: WAIT_CYCLES=0, DEPTH=256
    rst = 1'b1;
    sel = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1'b1, 2'b11, 8'h50, 16'hCAFE, 1'b0);
    issue(1'b0, 2'b00, 8'h50, 16'h0000, 1'b0);
    issue(1'b1, 2'b11, 8'hFF, 16'h1234, 1'b0);
    issue(1'b1, 2'b01, 8'hFF, 16'h0F0F, 1'b0);
    issue(1'b0, 2'b00, 8'hFF, 16'h0000, 1'b1);
    issue(1'b0, 2'b00, 8'h50, 16'h0000, 1'b0);
    random_ops(150);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_multicycle_mem_responder
`default_nettype wire
